// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encoding and parameter defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int         AW_DEF     = 4;
  localparam int         DW_DEF     = 8;
  localparam logic [3:0] HLT_OP_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_INCR  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 2^AW x DW program RAM, synchronous write, registered read.
module prog_mem
  import fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // The array itself is never reset so a program survives CLRn.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM, instruction register and opcode/operand decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              AW     = AW_DEF,
  parameter int              DW     = DW_DEF,
  parameter logic [DW/2-1:0] HLT_OP = HLT_OP_DEF
) (
  input  logic            clk,
  input  logic            CLRn,
  input  logic            run,
  input  logic [AW-1:0]   PC_addr,
  output logic            IPC,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [DW-1:0]   prog_data,
  output logic [DW-1:0]   IR,
  output logic [DW/2-1:0] opcode,
  output logic [DW/2-1:0] operand,
  output logic            ir_valid,
  input  logic            exec_done,
  output logic            halted
);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] w_mem_q;
  logic          w_mem_we;
  logic          w_mem_re;

  assign w_mem_we = prog_we && (r_state == ST_IDLE);
  assign w_mem_re = (r_state == ST_FETCH);

  prog_mem #(
    .AW(AW),
    .DW(DW)
  ) u_prog_mem (
    .clk     (clk),
    .rst_n   (CLRn),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (w_mem_re),
    .i_raddr (PC_addr),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_LOAD;
      ST_LOAD:  w_next = (w_mem_q[DW-1:DW/2] == HLT_OP) ? ST_HALT : ST_INCR;
      ST_INCR:  w_next = ST_WAIT;
      ST_WAIT:  if (exec_done) w_next = run ? ST_FETCH : ST_IDLE;
      ST_HALT:  if (!run) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    IPC      = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (r_state)
      ST_INCR: IPC      = 1'b1;
      ST_WAIT: ir_valid = 1'b1;
      ST_HALT: halted   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      r_ir <= '0;
    end else if (r_state == ST_LOAD) begin
      r_ir <= w_mem_q;
    end
  end

  assign IR      = r_ir;
  assign opcode  = r_ir[DW-1:DW/2];
  assign operand = r_ir[DW/2-1:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 4: program address width; it matches the PC_addr width.
REQ-002 Parameter DW, default 8: instruction width, split as opcode [DW-1:DW/2] and operand [DW/2-1:0].
REQ-003 Parameter HLT_OP, default 4'hF: opcode that halts the fetch sequence.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 CLRn  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  level-sensitive; 1 enables instruction fetching.
REQ-007 PC_addr  in  AW  current program counter value from the PC block.
REQ-008 IPC  out  1  one-cycle increment request to the PC block.
REQ-009 prog_we  in  1  program memory write strobe.
REQ-010 prog_addr  in  AW  program memory write address.
REQ-011 prog_data  in  DW  program memory write data.
REQ-012 IR  out  DW  instruction register.
REQ-013 opcode  out  DW/2  IR upper half, combinational from IR.
REQ-014 operand  out  DW/2  IR lower half, combinational from IR.
REQ-015 ir_valid  out  1  IR holds an instruction awaiting execution.
REQ-016 exec_done  in  1  execute stage has consumed IR.
REQ-017 halted  out  1  a HLT_OP instruction was fetched.

Function
REQ-018 The FSM SHALL have six states: IDLE, FETCH, LOAD, INCR, WAIT, HALT.
REQ-019 IDLE: IDLE -> FETCH when run=1; otherwise it stays in IDLE.
REQ-020 FETCH: register mem[PC_addr] into mem_q; the next state is LOAD.
REQ-021 LOAD: IR <= mem_q; the next state is HALT if mem_q opcode == HLT_OP, else INCR.
REQ-022 INCR: IPC=1 for exactly this one cycle; the next state is WAIT.
REQ-023 IPC SHALL be 0 in every state other than INCR.
REQ-024 WAIT: ir_valid=1; on exec_done=1 go to FETCH if run=1, else IDLE; otherwise stay in WAIT.
REQ-025 exec_done SHALL be ignored in every state except WAIT.
REQ-026 IR SHALL change only in LOAD and stays stable throughout WAIT and HALT.
REQ-027 HALT: halted=1, ir_valid=0, IPC=0; HALT -> IDLE when run=0; otherwise it stays in HALT.
REQ-028 Latency: ir_valid SHALL rise 3 cycles after the first FETCH cycle (FETCH, LOAD, INCR, then WAIT).
REQ-029 In WAIT, PC_addr already holds the incremented value; the next FETCH SHALL use it.
REQ-030 PC wrap-around from 2^AW-1 to 0 SHALL be handled by the PC block; instr_fetch needs no special case.
REQ-031 A memory write SHALL occur only when prog_we=1 and the state is IDLE; prog_we in any other state SHALL be ignored.
REQ-032 When run falls during FETCH, LOAD or INCR, the current instruction SHALL complete through WAIT before IDLE is entered.

Reset
REQ-033 On CLRn=0, asynchronously: state=IDLE, IR=0, mem_q=0, IPC=0, ir_valid=0, halted=0.
REQ-034 Reset SHALL NOT clear program memory contents.
REQ-035 Reset asserted mid-instruction SHALL abort it without an IPC pulse and without a partial IR update.
REQ-036 After CLRn rises, the first FETCH SHALL occur on the first clock edge with run=1.

Structure
REQ-037 Shared package fetch_pkg SHALL hold the FSM state encoding, HLT_OP, and the AW/DW defaults.
REQ-038 Sub-module prog_mem SHALL be a 2^AW x DW RAM with synchronous write, registered read and no reset.
REQ-039 instr_fetch SHALL contain the FSM, the IR and the output decode.

Verification
REQ-040 Load mem[0]=8'h12, mem[1]=8'h34, run=1, exec_done pulsed one cycle after each ir_valid rise -> IR=8'h12, then IR=8'h34; one IPC per instruction; ir_valid rises 3 cycles after FETCH.
REQ-041 Load mem[2]=8'hF0 and run from PC=0 -> halted=1 with IR=8'hF0; no IPC after the HLT load; PC_addr stays 2; run=0 returns the FSM to IDLE.
REQ-042 Hold exec_done=0 for 10 cycles in WAIT -> ir_valid stays 1, IR is stable, IPC=0 throughout.
REQ-043 Pulse CLRn=0 during LOAD -> all outputs are 0 immediately; mem contents persist; no IPC is observed.
REQ-044 Run 16 non-halt instructions from PC=0 -> PC wraps to 0 and the 17th fetch returns mem[0].
REQ-045 Pulse prog_we with prog_data=8'hAA during WAIT -> the target word is unchanged.
